ship_weapon_ctrl: RTL

Player-side controller that drives the shared fire interface sampled by every enemy instance: ss_angle_state, fire_mode and a level fire pulse with cooldown. It turns debounced buttons into ship rotation, weapon mode selection and shots, and consumes the enemy-side kill and collision events to track lives, game-over and ultimate charges. It sits between the input-conditioning logic and the enemy array, with its outputs fanned out to all enemies and to the renderer.

---
 rtl/ship_weapon_ctrl_pkg.sv | 29 ++
 rtl/ship_weapon_ctrl_hold_repeat.sv | 46 ++++
 rtl/ship_weapon_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ship_weapon_ctrl_pkg.sv
// Shared game definitions: fire-mode encodings, ship angle width and the
// weapon FSM state encoding used by the player controller and the enemies.
package ship_weapon_ctrl_pkg;

  localparam int ANGLE_W = 4;
  // Wide enough for the longest cooldown / invulnerability window.
  localparam int CNT_W   = 26;

  localparam logic [1:0] MODE_NARROW = 2'd0;
  localparam logic [1:0] MODE_WIDE   = 2'd1;
  localparam logic [1:0] MODE_SNIPER = 2'd2;
  localparam logic [1:0] MODE_ULT    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_COOL = 2'd2
  } wstate_e;

  // Only the three user modes rotate; the ultimate is entered by charge spend.
  function automatic logic [1:0] next_user_mode(input logic [1:0] m);
    case (m)
      MODE_NARROW: next_user_mode = MODE_WIDE;
      MODE_WIDE:   next_user_mode = MODE_SNIPER;
      default:     next_user_mode = MODE_NARROW;
    endcase
  endfunction

endpackage

// File: rtl/ship_weapon_ctrl_hold_repeat.sv
// Edge-plus-autorepeat for one held request: a step on the rising edge, then
// one step every ROT_PERIOD cycles while the request stays high.
module ship_weapon_ctrl_hold_repeat #(
  parameter int ROT_PERIOD = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_i,
  output logic step_o
);

  localparam int CW = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;

  logic          req_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    step_o = 1'b0;
    if (en_i) begin
      if (!req_i) begin
        cnt_d = '0;
      end else if (!req_q) begin
        step_o = 1'b1;
        cnt_d  = '0;
      end else if (cnt_q == CW'(ROT_PERIOD - 1)) begin
        step_o = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      req_q <= req_i;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ship_weapon_ctrl.sv
// Player ship controller: rotation, weapon mode/shot FSM with cooldown, and
// lives / invulnerability / ultimate-charge bookkeeping from enemy events.
module ship_weapon_ctrl
  import ship_weapon_ctrl_pkg::*;
#(
  parameter int ROT_PERIOD    = 12500000,
  parameter int PULSE_LEN     = 4,
  parameter int COOLDOWN_0    = 12500000,
  parameter int COOLDOWN_1    = 6250000,
  parameter int COOLDOWN_2    = 25000000,
  parameter int START_LIVES   = 3,
  parameter int ULT_KILLS     = 8,
  parameter int INVULN_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_fire,
  input  logic               btn_mode,
  input  logic               btn_ult,
  input  logic               kill,
  input  logic               collision,
  output logic [ANGLE_W-1:0] ss_angle_state,
  output logic [1:0]         fire_mode,
  output logic               fire,
  output logic [1:0]         lives,
  output logic [1:0]         ult_charges,
  output logic               game_over,
  output logic               invuln
);

  localparam int KW = (ULT_KILLS > 1) ? $clog2(ULT_KILLS) : 1;

  wstate_e            state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cool_last;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         saved_mode_q, saved_mode_d;
  logic               ult_fired_q, ult_fired_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [KW-1:0]      kill_cnt_q, kill_cnt_d;
  logic [1:0]         ult_q, ult_d;
  logic [1:0]         lives_q, lives_d;
  logic               game_over_q, game_over_d;
  logic [CNT_W-1:0]   inv_cnt_q, inv_cnt_d;
  logic               mode_prev_q, fire_prev_q, ult_prev_q, coll_prev_q;
  logic               mode_edge, fire_edge, ult_edge, coll_edge;
  logic               run, spend, earn;
  logic               step_left, step_right;

  assign run       = enable & ~game_over_q;
  assign mode_edge = btn_mode  & ~mode_prev_q;
  assign fire_edge = btn_fire  & ~fire_prev_q;
  assign ult_edge  = btn_ult   & ~ult_prev_q;
  assign coll_edge = collision & ~coll_prev_q;

  // Holding both directions cancels both requests rather than picking one.
  ship_weapon_ctrl_hold_repeat #(.ROT_PERIOD(ROT_PERIOD)) u_rep_left (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (run),
    .req_i  (btn_left & ~btn_right),
    .step_o (step_left)
  );

  ship_weapon_ctrl_hold_repeat #(.ROT_PERIOD(ROT_PERIOD)) u_rep_right (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (run),
    .req_i  (btn_right & ~btn_left),
    .step_o (step_right)
  );

  always_comb begin
    case (mode_q)
      MODE_NARROW: cool_last = CNT_W'(COOLDOWN_0 - 1);
      MODE_WIDE:   cool_last = CNT_W'(COOLDOWN_1 - 1);
      default:     cool_last = CNT_W'(COOLDOWN_2 - 1);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    saved_mode_d = saved_mode_q;
    ult_fired_d  = ult_fired_q;
    spend        = 1'b0;
    if (run) begin
      case (state_q)
        ST_IDLE: begin
          if (ult_edge && ult_q != 2'd0) begin
            saved_mode_d = mode_q;
            mode_d       = MODE_ULT;
            ult_fired_d  = 1'b1;
            spend        = 1'b1;
            state_d      = ST_FIRE;
            cnt_d        = '0;
          end else if (fire_edge) begin
            state_d = ST_FIRE;
            cnt_d   = '0;
          end else if (mode_edge) begin
            mode_d = next_user_mode(mode_q);
          end
        end
        ST_FIRE: begin
          if (cnt_q == CNT_W'(PULSE_LEN - 1)) begin
            state_d = ST_COOL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_COOL: begin
          if (cnt_q == cool_last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (ult_fired_q) begin
              mode_d      = saved_mode_q;
              ult_fired_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Enemies sample the angle during the pulse, so steps in FIRE are dropped.
  always_comb begin
    angle_d = angle_q;
    if (run && state_q != ST_FIRE) begin
      if (step_left) begin
        angle_d = angle_q - 1'b1;
      end else if (step_right) begin
        angle_d = angle_q + 1'b1;
      end
    end
  end

  always_comb begin
    kill_cnt_d  = kill_cnt_q;
    ult_d       = ult_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    inv_cnt_d   = inv_cnt_q;
    earn        = 1'b0;
    if (run) begin
      if (kill) begin
        // A spend in this cycle frees a slot, so saturation only applies otherwise.
        if (ult_q == 2'd3 && !spend) begin
          kill_cnt_d = '0;
        end else if (kill_cnt_q == KW'(ULT_KILLS - 1)) begin
          kill_cnt_d = '0;
          earn       = 1'b1;
        end else begin
          kill_cnt_d = kill_cnt_q + 1'b1;
        end
      end
      ult_d = ult_q + 2'(earn) - 2'(spend);
      if (inv_cnt_q != '0) begin
        inv_cnt_d = inv_cnt_q - 1'b1;
      end
      if (coll_edge && inv_cnt_q == '0) begin
        lives_d   = lives_q - 1'b1;
        inv_cnt_d = CNT_W'(INVULN_CYCLES);
        if (lives_q == 2'd1) begin
          game_over_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mode_q       <= MODE_NARROW;
      saved_mode_q <= MODE_NARROW;
      ult_fired_q  <= 1'b0;
      angle_q      <= '0;
      kill_cnt_q   <= '0;
      ult_q        <= 2'd0;
      lives_q      <= 2'(START_LIVES);
      game_over_q  <= 1'b0;
      inv_cnt_q    <= '0;
      mode_prev_q  <= 1'b0;
      fire_prev_q  <= 1'b0;
      ult_prev_q   <= 1'b0;
      coll_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      saved_mode_q <= saved_mode_d;
      ult_fired_q  <= ult_fired_d;
      angle_q      <= angle_d;
      kill_cnt_q   <= kill_cnt_d;
      ult_q        <= ult_d;
      lives_q      <= lives_d;
      game_over_q  <= game_over_d;
      inv_cnt_q    <= inv_cnt_d;
      mode_prev_q  <= btn_mode;
      fire_prev_q  <= btn_fire;
      ult_prev_q   <= btn_ult;
      coll_prev_q  <= collision;
    end
  end

  assign ss_angle_state = angle_q;
  assign fire_mode      = mode_q;
  assign fire           = run & (state_q == ST_FIRE);
  assign lives          = lives_q;
  assign ult_charges    = ult_q;
  assign game_over      = game_over_q;
  assign invuln         = (inv_cnt_q != '0);

endmodule
